z16_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the Z16 16-bit datapath: PC, decoder, register file, ALU.
- Replaces single-cycle execution with a FETCH/DECODE/EXEC/MEM state machine.
- Arbitrates one shared single-port memory between instruction fetch and load/store, using a req/ready handshake.
- Drives every datapath write-enable and mux select; flags a memory-timeout error.

---
 rtl/z16_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_z16_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_seq_ctrl.sv
// Z16 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM control with shared-memory
// arbitration, per-request wait counting and a sticky memory-timeout error.
module z16_seq_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_opcode,
    input  logic       i_dec_rd_wen,
    input  logic       i_br_eq,
    input  logic       i_br_gt,
    input  logic       i_stall,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_addr_sel,
    output logic       o_ir_wen,
    output logic       o_pc_wen,
    output logic [1:0] o_pc_sel,
    output logic       o_rd_wen,
    output logic [1:0] o_rd_sel,
    output logic [2:0] o_state,
    output logic       o_retire,
    output logic       o_error
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        ERROR  = 3'd7
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_JAL   = 4'hC;
    localparam logic [3:0] OP_JRL   = 4'hD;
    localparam logic [3:0] OP_BEQ   = 4'hE;
    localparam logic [3:0] OP_BGT   = 4'hF;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic             r_pending;
    logic             pending_nxt;
    logic [TMO_W-1:0] wait_cnt;
    logic [TMO_W-1:0] wait_nxt;
    logic             at_limit;
    logic             req;

    assign at_limit = (wait_cnt == TMO_LIMIT);

    // State, fetch-pending flag and memory wait counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= FETCH;
            r_pending <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            r_pending <= pending_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    // Next-state, wait-counter update and all datapath controls.
    // Outputs are forced low while reset is held so that an in-flight store
    // is dropped without a write strobe, whatever state the FSM was in.
    always_comb begin
        state_nxt   = state;
        pending_nxt = r_pending;
        wait_nxt    = wait_cnt;
        req         = 1'b0;
        o_mem_we    = 1'b0;
        o_addr_sel  = 1'b0;
        o_ir_wen    = 1'b0;
        o_pc_wen    = 1'b0;
        o_pc_sel    = 2'd0;
        o_rd_wen    = 1'b0;
        o_rd_sel    = 2'd0;
        o_retire    = 1'b0;
        o_error     = 1'b0;

        case (state)
            FETCH: begin
                // Once a fetch has been issued unacknowledged, stall can no
                // longer withdraw it.
                req = !i_stall || r_pending;
                if (req) begin
                    if (i_mem_ready) begin
                        o_ir_wen    = 1'b1;
                        pending_nxt = 1'b0;
                        state_nxt   = DECODE;
                    end else begin
                        pending_nxt = 1'b1;
                        if (at_limit) begin
                            state_nxt = ERROR;
                        end
                    end
                end
            end
            DECODE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                case (i_opcode)
                    OP_LOAD, OP_STORE: begin
                        state_nxt = MEM;
                    end
                    OP_JAL, OP_JRL: begin
                        o_rd_wen  = 1'b1;
                        o_rd_sel  = 2'd2;
                        o_pc_wen  = 1'b1;
                        o_pc_sel  = (i_opcode == OP_JAL) ? 2'd1 : 2'd2;
                        o_retire  = 1'b1;
                        state_nxt = FETCH;
                    end
                    OP_BEQ, OP_BGT: begin
                        o_pc_wen  = 1'b1;
                        if (i_opcode == OP_BEQ) begin
                            o_pc_sel = i_br_eq ? 2'd3 : 2'd0;
                        end else begin
                            o_pc_sel = i_br_gt ? 2'd3 : 2'd0;
                        end
                        o_retire  = 1'b1;
                        state_nxt = FETCH;
                    end
                    default: begin
                        o_rd_wen  = i_dec_rd_wen;
                        o_rd_sel  = 2'd0;
                        o_pc_wen  = 1'b1;
                        o_pc_sel  = 2'd0;
                        o_retire  = 1'b1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEM: begin
                req        = 1'b1;
                o_addr_sel = 1'b1;
                o_mem_we   = (i_opcode == OP_STORE);
                if (i_mem_ready) begin
                    if (i_opcode == OP_LOAD) begin
                        o_rd_wen = 1'b1;
                        o_rd_sel = 2'd1;
                    end
                    o_pc_wen  = 1'b1;
                    o_pc_sel  = 2'd0;
                    o_retire  = 1'b1;
                    state_nxt = FETCH;
                end else if (at_limit) begin
                    state_nxt = ERROR;
                end
            end
            ERROR: begin
                o_error = 1'b1;
            end
            default: begin
                state_nxt   = FETCH;
                pending_nxt = 1'b0;
                wait_nxt    = '0;
            end
        endcase

        // Ready on the limit cycle clears the count, so it wins over timeout.
        if (req) begin
            if (i_mem_ready) begin
                wait_nxt = '0;
            end else if (!at_limit) begin
                wait_nxt = wait_cnt + 1'b1;
            end
        end

        o_mem_req = req;
        o_state   = state;

        if (i_rst) begin
            o_mem_req  = 1'b0;
            o_mem_we   = 1'b0;
            o_addr_sel = 1'b0;
            o_ir_wen   = 1'b0;
            o_pc_wen   = 1'b0;
            o_pc_sel   = 2'd0;
            o_rd_wen   = 1'b0;
            o_rd_sel   = 2'd0;
            o_state    = 3'd0;
            o_retire   = 1'b0;
            o_error    = 1'b0;
        end
    end

endmodule

// File: tb/tb_z16_seq_ctrl.sv
// Randomized bench for z16_seq_ctrl: an instruction-level procedural model
// walks each instruction through its phases and predicts every output cycle.
module tb_z16_seq_ctrl;

    localparam int TMO       = 4;
    localparam int FETCH_MAX = 300;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [3:0] i_opcode;
    logic       i_dec_rd_wen;
    logic       i_br_eq;
    logic       i_br_gt;
    logic       i_stall;
    logic       i_mem_ready;
    logic       o_mem_req;
    logic       o_mem_we;
    logic       o_addr_sel;
    logic       o_ir_wen;
    logic       o_pc_wen;
    logic [1:0] o_pc_sel;
    logic       o_rd_wen;
    logic [1:0] o_rd_sel;
    logic [2:0] o_state;
    logic       o_retire;
    logic       o_error;

    int total = 0;
    int bad   = 0;

    // stimulus knobs; -1 disables a forced pattern
    int stall_pct   = 0;
    int ready_pct   = 100;
    int stall_first = -1;
    int fetch_wait  = -1;
    int mem_wait    = -1;
    int mem_abort   = -1;

    logic [14:0] obs;

    always #5 clk = ~clk;

    z16_seq_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_opcode     (i_opcode),
        .i_dec_rd_wen (i_dec_rd_wen),
        .i_br_eq      (i_br_eq),
        .i_br_gt      (i_br_gt),
        .i_stall      (i_stall),
        .i_mem_ready  (i_mem_ready),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_addr_sel   (o_addr_sel),
        .o_ir_wen     (o_ir_wen),
        .o_pc_wen     (o_pc_wen),
        .o_pc_sel     (o_pc_sel),
        .o_rd_wen     (o_rd_wen),
        .o_rd_sel     (o_rd_sel),
        .o_state      (o_state),
        .o_retire     (o_retire),
        .o_error      (o_error)
    );

    assign obs = {o_mem_req, o_mem_we, o_addr_sel, o_ir_wen, o_pc_wen, o_pc_sel,
                  o_rd_wen, o_rd_sel, o_state, o_retire, o_error};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (req,we,asel,ir,pcw,pcsel2,rdw,rdsel2,st3,ret,err)",
                     tag, got, exp);
        end
    endtask

    function automatic logic [14:0] pk(input int req, input int we, input int asel, input int ir,
                                       input int pcw, input int pcs, input int rdw, input int rds,
                                       input int st, input int ret, input int err);
        return {1'(req), 1'(we), 1'(asel), 1'(ir), 1'(pcw), 2'(pcs),
                1'(rdw), 2'(rds), 3'(st), 1'(ret), 1'(err)};
    endfunction

    function automatic logic pct(input int p);
        return ($urandom_range(99, 0) < p);
    endfunction

    // inputs are already driven (at posedge+1); sample mid-cycle, then advance
    task automatic cyc(input string tag, input logic [14:0] exp);
        #2;
        check_eq(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            i_stall     = pct(50);
            i_mem_ready = pct(50);
            i_opcode    = 4'($urandom_range(15, 0));
            cyc("reset", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        i_rst = 1'b0;
    endtask

    task automatic error_phase();
        for (int k = 0; k < 3; k++) begin
            i_stall     = pct(50);
            i_mem_ready = pct(50);
            cyc("error_sticky", pk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1));
        end
        do_reset(int'($urandom_range(3, 1)));
    endtask

    task automatic fetch_phase(output bit err);
        int   waits;
        bit   pend;
        int   c;
        logic s;
        logic r;
        waits = 0;
        pend  = 1'b0;
        err   = 1'b0;
        for (c = 0; c < FETCH_MAX; c++) begin
            s = (c < stall_first) ? 1'b1 : (c == stall_first) ? 1'b0 : pct(stall_pct);
            r = (fetch_wait >= 0) ? (waits == fetch_wait) : pct(ready_pct);
            i_stall     = s;
            i_mem_ready = r;
            if (s && !pend) begin
                cyc("fetch_stalled", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end else if (r) begin
                cyc("fetch_ack", pk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                return;
            end else begin
                cyc("fetch_wait", pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                if (waits == TMO) begin
                    err = 1'b1;
                    return;
                end
                waits++;
                pend = 1'b1;
            end
        end
        check_eq("fetch_bound", 32'(c), 32'(FETCH_MAX - 1));
        err = 1'b1;
    endtask

    task automatic mem_phase(input logic [3:0] op, output bit err, output bit aborted);
        int   waits;
        logic r;
        int   ld;
        int   st;
        waits   = 0;
        err     = 1'b0;
        aborted = 1'b0;
        ld      = int'(op == 4'hA);
        st      = int'(op == 4'hB);
        for (int c = 0; c <= TMO + 1; c++) begin
            if (c == mem_abort) begin
                aborted = 1'b1;
                return;
            end
            r = (mem_wait >= 0) ? (waits == mem_wait) : pct(ready_pct);
            i_stall     = pct(50);
            i_mem_ready = r;
            if (r) begin
                cyc("mem_ack", pk(1, st, 1, 0, 1, 0, ld, ld, 3, 1, 0));
                return;
            end
            cyc("mem_wait", pk(1, st, 1, 0, 0, 0, 0, 0, 3, 0, 0));
            if (waits == TMO) begin
                err = 1'b1;
                return;
            end
            waits++;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic rdw, input logic eq, input logic gt);
        bit          e;
        bit          ab;
        logic [14:0] ex;
        i_opcode = op;
        fetch_phase(e);
        if (e) begin
            error_phase();
            return;
        end
        i_stall     = pct(50);
        i_mem_ready = pct(50);
        cyc("decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        i_dec_rd_wen = rdw;
        i_br_eq      = eq;
        i_br_gt      = gt;
        i_stall      = pct(50);
        i_mem_ready  = pct(50);
        if (op <= 4'h9)                   ex = pk(0, 0, 0, 0, 1, 0, int'(rdw), 0, 2, 1, 0);
        else if (op == 4'hA || op == 4'hB) ex = pk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        else if (op == 4'hC)              ex = pk(0, 0, 0, 0, 1, 1, 1, 2, 2, 1, 0);
        else if (op == 4'hD)              ex = pk(0, 0, 0, 0, 1, 2, 1, 2, 2, 1, 0);
        else if (op == 4'hE)              ex = pk(0, 0, 0, 0, 1, eq ? 3 : 0, 0, 0, 2, 1, 0);
        else                              ex = pk(0, 0, 0, 0, 1, gt ? 3 : 0, 0, 0, 2, 1, 0);
        cyc("exec", ex);
        if (op == 4'hA || op == 4'hB) begin
            mem_phase(op, e, ab);
            if (ab) do_reset(2);
            else if (e) error_phase();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst        = 1'b1;
        i_opcode     = 4'h0;
        i_dec_rd_wen = 1'b0;
        i_br_eq      = 1'b0;
        i_br_gt      = 1'b0;
        i_stall      = 1'b0;
        i_mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);

        // zero-wait ALU op, then load with two wait cycles
        run_instr(4'h1, 1'b1, 1'b0, 1'b0);
        mem_wait = 2;
        run_instr(4'hA, 1'b0, 1'b0, 1'b0);
        mem_wait = -1;

        // branches taken / not taken, jumps
        run_instr(4'hE, 1'b1, 1'b1, 1'b0);
        run_instr(4'hE, 1'b1, 1'b0, 1'b1);
        run_instr(4'hF, 1'b0, 1'b0, 1'b1);
        run_instr(4'hC, 1'b0, 1'b0, 1'b0);
        run_instr(4'hD, 1'b0, 1'b0, 1'b0);

        // five stalled fetch cycles, then stall raised after an unacked fetch
        stall_first = 5;
        run_instr(4'h2, 1'b0, 1'b0, 1'b0);
        stall_first = 0;
        stall_pct   = 100;
        fetch_wait  = 3;
        run_instr(4'h3, 1'b1, 1'b0, 1'b0);
        stall_first = -1;
        stall_pct   = 0;

        // ready exactly on the limit cycle still completes
        fetch_wait = TMO;
        mem_wait   = TMO;
        run_instr(4'hB, 1'b0, 1'b0, 1'b0);
        fetch_wait = -1;

        // memory never ready -> ERROR (MEM, then FETCH)
        mem_wait = 99;
        run_instr(4'hA, 1'b1, 1'b0, 1'b0);
        fetch_wait = 99;
        run_instr(4'h0, 1'b1, 1'b0, 1'b0);
        fetch_wait = -1;

        // reset during a stalled store
        mem_abort = 2;
        run_instr(4'hB, 1'b0, 1'b0, 1'b0);
        mem_abort = -1;
        mem_wait  = -1;
        run_instr(4'h5, 1'b1, 1'b0, 1'b0);

        // randomized traffic
        stall_pct = 25;
        ready_pct = 65;
        for (int n = 0; n < 400; n++) begin
            run_instr(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                      1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
